// File: rtl/ea_seq.sv
// rtl/ea_seq.sv - 6502 effective-address sequencer: drives the ALU operand/op interface and issues pointer reads
module ea_seq #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [3:0]  mode_i,
  input  logic [15:0] operand_i,
  input  logic [7:0]  x_i,
  input  logic [7:0]  y_i,
  output logic [15:0] alu_op_A_o,
  output logic [15:0] alu_op_B_o,
  output logic [1:0]  alu_op_o,
  input  logic [15:0] alu_res_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] ea_o,
  output logic        page_cross_o,
  output logic        err_o
);

  localparam logic [1:0] ALU_BYPASS_A     = 2'd0;
  localparam logic [1:0] ALU_ADD          = 2'd1;
  localparam logic [1:0] ALU_ADD_ZEROPAGE = 2'd2;

  localparam logic [3:0] M_IMM  = 4'd0;
  localparam logic [3:0] M_ZP   = 4'd1;
  localparam logic [3:0] M_ZPX  = 4'd2;
  localparam logic [3:0] M_ZPY  = 4'd3;
  localparam logic [3:0] M_ABS  = 4'd4;
  localparam logic [3:0] M_ABSX = 4'd5;
  localparam logic [3:0] M_ABSY = 4'd6;
  localparam logic [3:0] M_INDX = 4'd7;
  localparam logic [3:0] M_INDY = 4'd8;
  localparam logic [3:0] M_IND  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_RD_LO, S_RD_HI, S_POST, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mode_q;
  logic [15:0] operand_q;
  logic [7:0]  x_q, y_q;
  logic [15:0] tmp_q;   // ALU result, doubles as the read pointer in indirect modes
  logic [15:0] base_q;
  logic [7:0]  lo_q;
  logic        err_q;
  logic [31:0] wait_cnt_q;
  logic        timeout;

  assign busy_o = (state_q != S_IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    alu_op_o   = ALU_BYPASS_A;
    alu_op_A_o = 16'h0000;
    alu_op_B_o = 16'h0000;
    mem_req_o  = 1'b0;
    mem_addr_o = 16'h0000;
    timeout    = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_CALC;
      S_CALC: begin
        case (mode_q)
          M_IMM, M_ABS, M_IND: alu_op_A_o = operand_q;
          M_ZP: begin
            alu_op_o   = ALU_ADD_ZEROPAGE;
            alu_op_A_o = operand_q;
          end
          M_ZPX, M_ZPY, M_INDX: begin
            alu_op_o   = ALU_ADD_ZEROPAGE;
            alu_op_A_o = operand_q;
            alu_op_B_o = {8'h00, (mode_q == M_ZPY) ? y_q : x_q};
          end
          M_ABSX, M_ABSY: begin
            alu_op_o   = ALU_ADD;
            alu_op_A_o = operand_q;
            alu_op_B_o = {8'h00, (mode_q == M_ABSY) ? y_q : x_q};
          end
          M_INDY: alu_op_A_o = {8'h00, operand_q[7:0]};
          default: ;
        endcase
        state_d = (mode_q inside {M_INDX, M_INDY, M_IND}) ? S_RD_LO : S_DONE;
      end
      S_RD_LO, S_RD_HI: begin
        mem_req_o  = 1'b1;
        mem_addr_o = tmp_q;
        if (state_q == S_RD_LO) begin
          alu_op_o   = ALU_ADD_ZEROPAGE;
          alu_op_A_o = tmp_q;
          alu_op_B_o = 16'h0001;
        end
        timeout = (MEM_TIMEOUT != 0) && !mem_valid_i && (wait_cnt_q == MEM_TIMEOUT - 1);
        if (mem_valid_i) begin
          if (state_q == S_RD_LO)     state_d = S_RD_HI;
          else if (mode_q == M_INDY)  state_d = S_POST;
          else                        state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
        end
      end
      S_POST: begin
        alu_op_o   = ALU_ADD;
        alu_op_A_o = tmp_q;
        alu_op_B_o = {8'h00, y_q};
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_q       <= 4'h0;
      operand_q    <= 16'h0000;
      x_q          <= 8'h00;
      y_q          <= 8'h00;
      tmp_q        <= 16'h0000;
      base_q       <= 16'h0000;
      lo_q         <= 8'h00;
      err_q        <= 1'b0;
      wait_cnt_q   <= 32'd0;
      done_o       <= 1'b0;
      ea_o         <= 16'h0000;
      page_cross_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      wait_cnt_q <= (mem_req_o && !mem_valid_i && !timeout) ? wait_cnt_q + 32'd1 : 32'd0;
      case (state_q)
        S_IDLE: if (start_i) begin
          mode_q    <= mode_i;
          operand_q <= operand_i;
          x_q       <= x_i;
          y_q       <= y_i;
          err_q     <= 1'b0;
        end
        S_CALC: begin
          tmp_q  <= alu_res_i;
          base_q <= operand_q;
          err_q  <= (mode_q > M_IND);
        end
        S_RD_LO: begin
          if (mem_valid_i) begin
            lo_q <= mem_rdata_i;
            // JMP (ind) keeps the pointer high byte: the 6502 page-wrap bug
            tmp_q <= (mode_q == M_IND) ? {tmp_q[15:8], alu_res_i[7:0]} : {8'h00, alu_res_i[7:0]};
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        S_RD_HI: begin
          if (mem_valid_i) begin
            tmp_q  <= {mem_rdata_i, lo_q};
            base_q <= {mem_rdata_i, lo_q};
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        S_POST: tmp_q <= alu_res_i;
        S_DONE: begin
          done_o       <= 1'b1;
          err_o        <= err_q;
          ea_o         <= err_q ? 16'h0000 : tmp_q;
          page_cross_o <= !err_q && (mode_q inside {M_ABSX, M_ABSY, M_INDY}) &&
                          (tmp_q[15:8] != base_q[15:8]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ea_seq.sv
// tb/tb_ea_seq.sv - self-checking bench for ea_seq with memory responder, ALU model and reference model
module tb_ea_seq;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mode = '0;
  logic [15:0] operand = '0;
  logic [7:0]  x = '0, y = '0;
  logic [15:0] alu_a, alu_b, alu_res, mem_addr, ea;
  logic [1:0]  alu_op;
  logic        mem_req, mem_valid, busy, done, page_cross, err;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];
  int          cur_delay = 0;
  logic        stall = 1'b0;
  logic        noise = 1'b0;
  int          wcnt = 0;
  int          rd_cnt = 0;
  logic [15:0] rd_log [0:15];
  int          stable_err = 0;
  int          req_cycles = 0;
  logic        waiting = 1'b0;
  logic [15:0] prev_addr = '0;

  int checks = 0;
  int failures = 0;
  int vidx = 0;

  always #5 clk = ~clk;

  ea_seq #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .mode_i(mode), .operand_i(operand),
    .x_i(x), .y_i(y), .alu_op_A_o(alu_a), .alu_op_B_o(alu_b), .alu_op_o(alu_op),
    .alu_res_i(alu_res), .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_valid_i(mem_valid),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done), .ea_o(ea),
    .page_cross_o(page_cross), .err_o(err)
  );

  // ALU: 0 BYPASS_A, 1 ADD, 2 ADD_ZEROPAGE
  always_comb begin
    alu_res = 16'h0000;
    case (alu_op)
      2'd0: alu_res = alu_a;
      2'd1: alu_res = alu_a + alu_b;
      2'd2: alu_res = {8'h00, alu_a[7:0] + alu_b[7:0]};
      default: alu_res = 16'h0000;
    endcase
  end

  assign mem_valid = mem_req ? (!stall && wcnt >= cur_delay) : noise;
  assign mem_rdata = mem[mem_addr];

  always @(negedge clk) noise <= 1'($urandom);

  always @(posedge clk) begin
    wcnt <= (!mem_req || mem_valid) ? 0 : wcnt + 1;
    if (mem_req) req_cycles <= req_cycles + 1;
    if (mem_req && mem_valid) begin
      rd_log[rd_cnt % 16] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (waiting && mem_req && mem_addr != prev_addr) stable_err <= stable_err + 1;
    waiting   <= mem_req && !mem_valid;
    prev_addr <= mem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", name, vidx, act, exp);
    end
  endtask

  // Reference: effective address from 6502 addressing rules
  task automatic model(input logic [3:0] m, input logic [15:0] op, input logic [7:0] xv,
                       input logic [7:0] yv, input int d,
                       output logic [15:0] e, output logic pc, output logic er, output int lat,
                       output int n, output logic [15:0] a0, output logic [15:0] a1);
    logic [15:0] base;
    e = 16'h0; pc = 1'b0; er = 1'b0; lat = 2; n = 0; a0 = 16'h0; a1 = 16'h0;
    case (m)
      4'd0, 4'd4: e = op;
      4'd1: e = {8'h00, op[7:0]};
      4'd2: e = 16'((int'(op[7:0]) + int'(xv)) % 256);
      4'd3: e = 16'((int'(op[7:0]) + int'(yv)) % 256);
      4'd5, 4'd6: begin
        e  = 16'((int'(op) + int'((m == 4'd5) ? xv : yv)) % 65536);
        pc = (e[15:8] != op[15:8]);
      end
      4'd7, 4'd8: begin
        a0 = (m == 4'd7) ? 16'((int'(op[7:0]) + int'(xv)) % 256) : {8'h00, op[7:0]};
        a1 = 16'((int'(a0) + 1) % 256);
        n = 2;
        base = {mem[a1], mem[a0]};
        if (m == 4'd7) begin
          e = base; lat = 4 + 2 * d;
        end else begin
          e = 16'((int'(base) + int'(yv)) % 65536);
          pc = (e[15:8] != base[15:8]);
          lat = 5 + 2 * d;
        end
      end
      4'd9: begin
        a0 = op;
        a1 = {op[15:8], 8'((int'(op[7:0]) + 1) % 256)};
        n = 2;
        e = {mem[a1], mem[a0]};
        lat = 4 + 2 * d;
      end
      default: er = 1'b1;
    endcase
  endtask

  task automatic run_op(input logic [3:0] m, input logic [15:0] op, input logic [7:0] xv,
                        input logic [7:0] yv, input int d, output int lat);
    cur_delay = d;
    @(negedge clk);
    start = 1'b1; mode = m; operand = op; x = xv; y = yv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (busy) begin
        start = 1'($urandom); mode = 4'($urandom); operand = 16'($urandom);
        x = 8'($urandom); y = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_vec(input logic [3:0] m, input logic [15:0] op, input logic [7:0] xv,
                        input logic [7:0] yv, input int d, input logic [15:0] xe,
                        input logic xpc, input logic xer, input int xlat);
    logic [15:0] me, a0, a1;
    logic mpc, mer;
    int mlat, n, lat, rd0, st0;
    model(m, op, xv, yv, d, me, mpc, mer, mlat, n, a0, a1);
    rd0 = rd_cnt; st0 = stable_err;
    run_op(m, op, xv, yv, d, lat);
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout vec=%0d got=none exp=done", vidx);
    end else begin
      chk("ea", 32'(ea), 32'(xe));
      chk("page_cross", 32'(page_cross), 32'(xpc));
      chk("err", 32'(err), 32'(xer));
      chk("latency", 32'(lat), 32'(xlat));
      chk("read_count", 32'(rd_cnt - rd0), 32'(n));
      if (n == 2 && rd_cnt - rd0 == 2)
        chk("read_addrs", {rd_log[rd0 % 16], rd_log[(rd0 + 1) % 16]}, {a0, a1});
      chk("addr_stable", 32'(stable_err - st0), 32'd0);
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);
      chk("ea_hold", 32'(ea), 32'(xe));
    end
  endtask

  typedef struct {
    logic [3:0]  mode;
    logic [15:0] op;
    logic [7:0]  x, y;
    int          dly;
    logic [15:0] wa0; logic [7:0] wd0;
    logic [15:0] wa1; logic [7:0] wd1;
    logic [15:0] ea;
    logic        pc, err;
    int          lat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int lat0, rd0, req0;
    logic [15:0] me, a0, a1;
    logic mpc, mer;
    int mlat, n;
    logic [3:0] rm;
    int rdly;
    logic [15:0] rop;
    logic [7:0] rx, ry;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    tbl[0] = '{4'd2, 16'h00F0, 8'h20, 8'h00, 0, 16'h8000, 8'h00, 16'h8001, 8'h00, 16'h0010, 1'b0, 1'b0, 2};
    tbl[1] = '{4'd5, 16'h12F0, 8'h20, 8'h00, 0, 16'h8000, 8'h00, 16'h8001, 8'h00, 16'h1310, 1'b1, 1'b0, 2};
    tbl[2] = '{4'd6, 16'h1200, 8'h00, 8'h05, 0, 16'h8000, 8'h00, 16'h8001, 8'h00, 16'h1205, 1'b0, 1'b0, 2};
    tbl[3] = '{4'd7, 16'h00FF, 8'h00, 8'h00, 0, 16'h00FF, 8'h34, 16'h0000, 8'h12, 16'h1234, 1'b0, 1'b0, 4};
    tbl[4] = '{4'd9, 16'h30FF, 8'h00, 8'h00, 0, 16'h30FF, 8'h80, 16'h3000, 8'h50, 16'h5080, 1'b0, 1'b0, 4};
    tbl[5] = '{4'd8, 16'h0040, 8'h00, 8'h20, 3, 16'h0040, 8'hF0, 16'h0041, 8'h12, 16'h1310, 1'b1, 1'b0, 11};
    tbl[6] = '{4'd0, 16'hBEEF, 8'h11, 8'h22, 0, 16'h8000, 8'h00, 16'h8001, 8'h00, 16'hBEEF, 1'b0, 1'b0, 2};
    tbl[7] = '{4'd1, 16'h12AB, 8'h11, 8'h22, 0, 16'h8000, 8'h00, 16'h8001, 8'h00, 16'h00AB, 1'b0, 1'b0, 2};
    tbl[8] = '{4'd15, 16'h1234, 8'h11, 8'h22, 0, 16'h8000, 8'h00, 16'h8001, 8'h00, 16'h0000, 1'b0, 1'b1, 2};
    tbl[9] = '{4'd8, 16'h00FF, 8'h00, 8'h01, 1, 16'h00FF, 8'h10, 16'h0000, 8'h20, 16'h2011, 1'b0, 1'b0, 7};

    // reset state
    #12;
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ea", 32'(ea), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_alu_ab", {alu_a, alu_b}, 0);
    @(negedge clk); rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      vidx = i;
      mem[tbl[i].wa0] = tbl[i].wd0;
      mem[tbl[i].wa1] = tbl[i].wd1;
      do_vec(tbl[i].mode, tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].dly,
             tbl[i].ea, tbl[i].pc, tbl[i].err, tbl[i].lat);
    end

    // reset while waiting in the second read
    vidx = 100;
    mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h12;
    cur_delay = 3;
    rd0 = rd_cnt;
    @(negedge clk);
    start = 1'b1; mode = 4'd8; operand = 16'h0040; y = 8'h20;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 50 && rd_cnt == rd0; k++) begin
      @(posedge clk); #1;
    end
    chk("rd_hi_reached", 32'(rd_cnt - rd0), 1);
    #1;
    chk("rd_hi_req", 32'(mem_req), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ea", 32'(ea), 0);
    chk("mid_rst_alu_op", 32'(alu_op), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", 32'(done), 0);
    end
    @(negedge clk); rstn = 1'b1;
    vidx = 101;
    do_vec(4'd12, 16'h5555, 8'h01, 8'h02, 0, 16'h0000, 1'b0, 1'b1, 2);

    // memory never answers: timeout after TMO request cycles
    vidx = 102;
    stall = 1'b1;
    rd0 = rd_cnt; req0 = req_cycles;
    run_op(4'd7, 16'h0010, 8'h01, 8'h00, 0, lat0);
    stall = 1'b0;
    chk("tmo_latency", 32'(lat0), 32'(TMO + 2));
    chk("tmo_err", 32'(err), 1);
    chk("tmo_ea", 32'(ea), 0);
    chk("tmo_pc", 32'(page_cross), 0);
    chk("tmo_req_cycles", 32'(req_cycles - req0), 32'(TMO));
    chk("tmo_reads", 32'(rd_cnt - rd0), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      vidx = 200 + i;
      rm   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rop  = 16'($urandom);
      rx   = 8'($urandom);
      ry   = 8'($urandom);
      rdly = $urandom_range(0, 3);
      model(rm, rop, rx, ry, rdly, me, mpc, mer, mlat, n, a0, a1);
      do_vec(rm, rop, rx, ry, rdly, me, mpc, mer, mlat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
